// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped one-word-line data cache:
// word width, slow-memory delay, FSM state encodings and the default line count.
package dcache_pkg;

  localparam int WORD          = 16;
  localparam int MEMDELAY      = 4;
  localparam int LINES_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_MISS_WAIT = 1'b1
  } state_e;

  // Hit test: the line is valid and its stored tag equals the request tag.
  // Tags are passed zero-extended to a full word so one helper serves any LINES.
  function automatic logic line_hit(input logic valid,
                                    input logic [WORD-1:0] stored_tag,
                                    input logic [WORD-1:0] req_tag);
    line_hit = valid && (stored_tag == req_tag);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag / valid / data storage for the data cache.
// One combinational read port and one synchronous write port; only the valid
// bits are reset, the tag and data arrays power up undefined.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = WORD - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [WORD-1:0]  rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [WORD-1:0]  wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [WORD-1:0]  data_q [LINES];

  // Next valid vector: any write installs (or keeps) the addressed line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits, cleared asynchronously so a reset empties the cache.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays: plain write port, contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through data cache with one-word lines in front of a
// slow memory. Loads that hit complete one cycle after acceptance; load misses
// fetch from slow memory and wait in MISS_WAIT for mem_mfc. Stores always go
// straight to memory and update the line only if it is resident.
// Build option: define DCACHE_WRITE_ALLOCATE_EN to also install the line on a
// store miss (memory-side traffic is identical either way).
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_rnotw,
  input  logic [WORD-1:0] cpu_addr,
  input  logic [WORD-1:0] cpu_wdata,
  output logic [WORD-1:0] cpu_rdata,
  output logic            cpu_ready,
  output logic            cpu_hit,
  output logic            mem_strobe,
  output logic            mem_rnotw,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_mfc
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD - IDX_W;

  state_e          state_q, state_d;
  logic [WORD-1:0] cpu_rdata_q, cpu_rdata_d;
  logic            cpu_ready_q, cpu_ready_d;
  logic            cpu_hit_q, cpu_hit_d;
  logic            mem_strobe_q, mem_strobe_d;
  logic            mem_rnotw_q, mem_rnotw_d;
  logic [WORD-1:0] mem_addr_q, mem_addr_d;
  logic [WORD-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [WORD-1:0]  rd_data;
  logic             lookup_hit;

  logic             arr_we;
  logic [IDX_W-1:0] arr_wr_idx;
  logic [TAG_W-1:0] arr_wr_tag;
  logic [WORD-1:0]  arr_wr_data;

  assign req_idx = cpu_addr[IDX_W-1:0];
  assign req_tag = cpu_addr[WORD-1:IDX_W];

  dcache_array #(
    .LINES (LINES)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_idx   (arr_wr_idx),
    .wr_tag   (arr_wr_tag),
    .wr_data  (arr_wr_data)
  );

  assign lookup_hit = line_hit(rd_valid, WORD'(rd_tag), WORD'(req_tag));

  // Next-state, registered-output and array-write decode for both FSM states.
  always_comb begin
    state_d      = state_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ready_d  = 1'b0;
    cpu_hit_d    = 1'b0;
    mem_strobe_d = 1'b0;
    mem_rnotw_d  = 1'b1;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    arr_we       = 1'b0;
    arr_wr_idx   = req_idx;
    arr_wr_tag   = req_tag;
    arr_wr_data  = cpu_wdata;

    case (state_q)
      ST_IDLE: begin
        // cpu_ready high means the CPU has not yet seen the last completion,
        // so a still-held request must not be taken a second time.
        if (cpu_req && !cpu_ready_q) begin
          if (cpu_rnotw) begin
            if (lookup_hit) begin
              cpu_ready_d = 1'b1;
              cpu_hit_d   = 1'b1;
              cpu_rdata_d = rd_data;
            end else begin
              mem_strobe_d = 1'b1;
              mem_rnotw_d  = 1'b1;
              mem_addr_d   = cpu_addr;
              state_d      = ST_MISS_WAIT;
            end
          end else begin
            // Write-through store: memory is always written, the CPU is
            // released immediately.
            mem_strobe_d = 1'b1;
            mem_rnotw_d  = 1'b0;
            mem_addr_d   = cpu_addr;
            mem_wdata_d  = cpu_wdata;
            cpu_ready_d  = 1'b1;
            cpu_hit_d    = lookup_hit;
            if (lookup_hit) begin
              arr_we = 1'b1;
            end else begin
`ifdef DCACHE_WRITE_ALLOCATE_EN
              arr_we = 1'b1;
`else
              arr_we = 1'b0;
`endif
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MISS_WAIT: begin
        // mem_addr still holds the missing address, so it supplies the
        // index and tag for the fill.
        if (mem_mfc) begin
          arr_we      = 1'b1;
          arr_wr_idx  = mem_addr_q[IDX_W-1:0];
          arr_wr_tag  = mem_addr_q[WORD-1:IDX_W];
          arr_wr_data = mem_rdata;
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b0;
          cpu_rdata_d = mem_rdata;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_MISS_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any miss in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cpu_rdata_q  <= {WORD{1'b0}};
      cpu_ready_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      mem_strobe_q <= 1'b0;
      mem_rnotw_q  <= 1'b1;
      mem_addr_q   <= {WORD{1'b0}};
      mem_wdata_q  <= {WORD{1'b0}};
    end else begin
      state_q      <= state_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_hit_q    <= cpu_hit_d;
      mem_strobe_q <= mem_strobe_d;
      mem_rnotw_q  <= mem_rnotw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_hit    = cpu_hit_q;
  assign mem_strobe = mem_strobe_q;
  assign mem_rnotw  = mem_rnotw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache (LINES=8) with a slowmem model, MEMDELAY=4.
// Expected CPU and memory-side responses are queued by the stimulus and
// checked by an independent monitor at every falling edge.
module tb_dcache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rnotw;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_hit;
  logic        mem_strobe;
  logic        mem_rnotw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_mfc;

  dcache #(.LINES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_rnotw  (cpu_rnotw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_hit    (cpu_hit),
    .mem_strobe (mem_strobe),
    .mem_rnotw  (mem_rnotw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_mfc    (mem_mfc)
  );

  always #5 clk = ~clk;

  // ---------------- slowmem model ----------------
  logic [15:0] m [0:255];
  logic        sm_preload;
  logic        sm_busy;
  int          sm_cnt;
  logic [15:0] sm_addr;

  // Writes land at once; reads return data with a one-cycle mfc MEMDELAY
  // cycles after the strobe is sampled.
  always @(posedge clk) begin
    if (sm_preload) begin
      for (int i = 0; i < 256; i++) m[i] <= 16'(i) ^ 16'hA5A5;
      m[5]      <= 16'h1234;
      m[13]     <= 16'h5678;
      sm_busy   <= 1'b0;
      sm_cnt    <= 0;
      sm_addr   <= 16'h0000;
      mem_mfc   <= 1'b0;
      mem_rdata <= 16'h0000;
    end else begin
      mem_mfc <= 1'b0;
      if (sm_busy) begin
        if (sm_cnt == 1) begin
          mem_mfc   <= 1'b1;
          mem_rdata <= m[sm_addr[7:0]];
          sm_busy   <= 1'b0;
        end else begin
          sm_cnt <= sm_cnt - 1;
        end
      end else if (mem_strobe) begin
        if (mem_rnotw) begin
          sm_busy <= 1'b1;
          sm_cnt  <= MEMDELAY;
          sm_addr <= mem_addr;
        end else begin
          m[mem_addr[7:0]] <= mem_wdata;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic hit; logic [15:0] rdata; int lat; } cpu_exp_t;
  typedef struct { logic rnotw; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
  typedef struct { string nm; int act; int exp; } dchk_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  dchk_t    dchk_q[$];

  int edge_cnt = 0;
  int accept_edge = 0;
  int ready_cnt = 0;
  int mfc_cnt = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_rdata;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    cpu_exp_t ce;
    mem_exp_t me;
    dchk_t    dc;
    forever begin
      @(negedge clk);
      if (mem_mfc === 1'b1) mfc_cnt++;
      if (reset) begin
        check("rst_ctrl", 32'({cpu_ready, cpu_hit, mem_strobe, mem_rnotw}), 32'h1);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      end else begin
        if (cpu_ready === 1'b1) begin
          ready_cnt++;
          if (cpu_q.size() == 0) begin
            check("unexpected_ready", 32'(cpu_ready), 32'h0);
          end else begin
            ce = cpu_q.pop_front();
            check("ready_hit", 32'(cpu_hit), 32'(ce.hit));
            check("ready_rdata", 32'(cpu_rdata), 32'(ce.rdata));
            check("ready_latency", 32'(edge_cnt - accept_edge + 1), 32'(ce.lat));
          end
        end else begin
          check("hit_without_ready", 32'(cpu_hit), 32'h0);
        end
        if (mem_strobe === 1'b1) begin
          if (mem_q.size() == 0) begin
            check("unexpected_strobe", 32'(mem_strobe), 32'h0);
          end else begin
            me = mem_q.pop_front();
            check("mem_rnotw", 32'(mem_rnotw), 32'(me.rnotw));
            check("mem_addr", 32'(mem_addr), 32'(me.addr));
            if (!me.rnotw) check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
          end
        end else begin
          check("mem_rnotw_idle", 32'(mem_rnotw), 32'h1);
        end
      end
      while (dchk_q.size() > 0) begin
        dc = dchk_q.pop_front();
        check(dc.nm, 32'(dc.act), 32'(dc.exp));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic rnotw, input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk); #1;
    cpu_req     = 1'b1;
    cpu_rnotw   = rnotw;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    accept_edge = edge_cnt + 1;
  endtask

  task automatic wait_ready(input string nm);
    int target;
    int n;
    target = ready_cnt + 1;
    n = 0;
    while (ready_cnt < target && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (ready_cnt < target) dchk_q.push_back('{nm, ready_cnt, target});
    cpu_req = 1'b0;
  endtask

  task automatic load(input logic [15:0] addr, input logic exp_hit, input logic [15:0] exp_data);
    cpu_q.push_back('{exp_hit, exp_data, exp_hit ? 1 : 7});
    if (!exp_hit) mem_q.push_back('{1'b1, addr, 16'h0000});
    issue(1'b1, addr, 16'h0000);
    wait_ready("load_timeout");
    last_rdata = exp_data;
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data, input logic exp_hit);
    cpu_q.push_back('{exp_hit, last_rdata, 1});
    mem_q.push_back('{1'b0, addr, data});
    issue(1'b0, addr, data);
    wait_ready("store_timeout");
  endtask

  initial begin
    int mfc_before;
    reset      = 1'b1;
    sm_preload = 1'b1;
    cpu_req    = 1'b0;
    cpu_rnotw  = 1'b1;
    cpu_addr   = 16'h0000;
    cpu_wdata  = 16'h0000;
    last_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    reset      = 1'b0;
    sm_preload = 1'b0;

    load(16'h0005, 1'b0, 16'h1234);   // cold miss, 7 cycles
    load(16'h0005, 1'b1, 16'h1234);   // hit, 1 cycle, no strobe
    load(16'h000D, 1'b0, 16'h5678);   // same index, evicts
    load(16'h0005, 1'b0, 16'h1234);   // misses again
    store(16'h0005, 16'hBEEF, 1'b1);  // store hit, rdata holds
    load(16'h0005, 1'b1, 16'hBEEF);
    dchk_q.push_back('{"slowmem_m5", int'(m[5]), 16'hBEEF});
    store(16'h0020, 16'h00AA, 1'b0);  // store miss
`ifdef DCACHE_WRITE_ALLOCATE_EN
    load(16'h0020, 1'b1, 16'h00AA);
`else
    load(16'h0020, 1'b0, 16'h00AA);
`endif

    // Reset three cycles into a miss: no completion, late mfc ignored.
    mfc_before = mfc_cnt;
    mem_q.push_back('{1'b1, 16'h000D, 16'h0000});
    issue(1'b1, 16'h000D, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    dchk_q.push_back('{"late_mfc_seen", mfc_cnt - mfc_before, 1});
    last_rdata = 16'h0000;
    load(16'h000D, 1'b0, 16'h5678);   // valid bits cleared by reset
    load(16'h0005, 1'b0, 16'hBEEF);

    dchk_q.push_back('{"cpu_q_drained", cpu_q.size(), 0});
    dchk_q.push_back('{"mem_q_drained", mem_q.size(), 0});
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have parameter LINES, default 8, meaning the number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 The block SHALL have the following ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  load/store request from the processor memory stage; held until cpu_ready.
- cpu_rnotw  input  1  1 = load, 0 = store.
- cpu_addr  input  16  word address.
- cpu_wdata  input  16  store data.
- cpu_rdata  output  16  load data, valid while cpu_ready=1.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_hit  output  1  qualifies cpu_ready: 1 = request hit in cache.
- mem_strobe  output  1  slowmem request strobe, one-cycle pulse.
- mem_rnotw  output  1  slowmem direction.
- mem_addr  output  16  slowmem address.
- mem_wdata  output  16  slowmem write data.
- mem_rdata  input  16  slowmem read data, valid when mem_mfc=1.
- mem_mfc  input  1  slowmem fetch-complete, one-cycle pulse.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 Address split SHALL be index = cpu_addr[log2(LINES)-1:0] and tag = remaining upper bits; each line holds valid, tag and 16-bit data.
REQ-005 The FSM SHALL have states IDLE and MISS_WAIT.
REQ-006 In IDLE, a request SHALL be accepted at a posedge with cpu_req=1 and cpu_ready=0; in MISS_WAIT, cpu_req SHALL be ignored.
- Consequence: the peak rate is one request per 2 cycles.
REQ-007 Load hit (valid and tag match) SHALL, on the edge after acceptance, produce:
- cpu_ready=1, cpu_hit=1, cpu_rdata=line data;
- state remains IDLE.
REQ-008 Load miss SHALL, on the edge after acceptance, produce:
- mem_strobe=1, mem_rnotw=1, mem_addr=cpu_addr;
- transition to MISS_WAIT.
REQ-009 In MISS_WAIT, mem_strobe SHALL be 0; the posedge sampling mem_mfc=1 SHALL:
- write line {valid=1, tag, mem_rdata};
- set cpu_ready=1, cpu_hit=0, cpu_rdata=mem_rdata;
- return to IDLE.
REQ-010 Store (write-through) SHALL, on the edge after acceptance, produce:
- mem_strobe=1, mem_rnotw=0, mem_addr/mem_wdata = request values;
- cpu_ready=1, cpu_hit=hit status;
- on hit, the line data updated to cpu_wdata;
- state remains IDLE.
REQ-011 mem_strobe, cpu_ready and cpu_hit SHALL be single-cycle pulses.
REQ-012 When not asserted, mem_rnotw SHALL be 1 and cpu_rdata SHALL hold its last value.
REQ-013 mem_mfc in IDLE SHALL be ignored (stale/late completions).
REQ-014 The block SHALL NOT issue a mem_strobe while in MISS_WAIT, so the slowmem write-satisfies-read path is never exercised.
REQ-015 Miss latency with MEMDELAY=4 SHALL be cpu_ready 7 cycles after the acceptance edge; hit latency SHALL be 1 cycle.

Reset
REQ-016 Reset SHALL asynchronously clear:
- all valid bits;
- state to IDLE;
- cpu_ready, cpu_hit and mem_strobe to 0;
- mem_rnotw to 1;
- cpu_rdata, mem_addr and mem_wdata to 0.
REQ-017 Reset during MISS_WAIT SHALL abandon the miss with no cpu_ready; a subsequent mem_mfc SHALL be ignored per REQ-013.
REQ-018 Tag and data arrays need not be reset.

Configuration
REQ-019 With DCACHE_WRITE_ALLOCATE_EN defined, a store miss SHALL also install the line {valid=1, tag, cpu_wdata}.
REQ-020 With DCACHE_WRITE_ALLOCATE_EN undefined, a store miss SHALL leave the cache unchanged (no-write-allocate).
REQ-021 Memory-side behaviour SHALL be identical in both builds.

Structure
REQ-022 The shared package SHALL hold WORD width, the MEMDELAY constant, the FSM state encodings and the LINES default.
REQ-023 Tag, valid and data storage SHALL be sub-module dcache_array: one read port, one write port, valid clear on reset.
- The FSM and handshake logic SHALL reside in dcache.

Verification
REQ-024 The bench SHALL use the team slowmem model with MEMDELAY=4 and cover these scenarios:
- Cold load at 0x0005 (mem=0x1234) -> mem_strobe read at 0x0005; cpu_ready with cpu_hit=0 and cpu_rdata=0x1234 at 7 cycles.
- Repeat load at 0x0005 -> cpu_ready, cpu_hit=1, rdata=0x1234 at 1 cycle, no mem_strobe.
- Load 0x000D (same index 5, LINES=8) -> miss and eviction; a following load at 0x0005 misses again.
- Store 0x0005=0xBEEF on a resident line -> write strobe with cpu_hit=1; following load hits with 0xBEEF; slowmem m[5]=0xBEEF.
- Store miss at 0x0020=0x00AA, then load 0x0020 -> hit if DCACHE_WRITE_ALLOCATE_EN is defined, else miss; rdata=0x00AA in both builds.
- Reset asserted 3 cycles into a miss -> no cpu_ready; late mfc ignored; next load to that address misses.
